// File: rtl/load_store_unit_if.sv
// CPU-side request/response and memory-side access signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the CPU/memory view.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  mem_type_i;
  logic        mem_sign_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_write_i, mem_type_i, mem_sign_i, addr_i, wdata_i,
           mem_ready_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output req_valid_i, req_write_i, mem_type_i, mem_sign_i, addr_i, wdata_i,
           mem_ready_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit with a four-state access FSM.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses over two beats; otherwise they error.
module load_store_unit (
  input  logic              clk_i,
  input  logic              rst_i,
  load_store_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t      state_q, state_d;
  logic        write_q, sign_q, err_q, split_q;
  logic [1:0]  type_q;
  logic [31:0] addr_q, wdata_q, lo_word_q, rdata_q;

  logic [3:0]  req_size;
  logic        req_err, req_split, accept, in_acc, final_beat;
  logic [3:0]  size_mask;
  logic [7:0]  strb_span;
  logic [31:0] wdata_sized, load_word, load_ext;
  logic [63:0] wdata_span, load_pair;

  always_comb begin
    case (bus.mem_type_i)
      2'b00:   req_size = 4'd1;
      2'b01:   req_size = 4'd2;
      default: req_size = 4'd4;
    endcase
  end

`ifdef MISALIGN_SPLIT_EN
  logic req_crosses;
  assign req_crosses = ({2'b00, bus.addr_i[1:0]} + req_size) > 4'd4;
  assign req_err     = (bus.mem_type_i == 2'b11);
  assign req_split   = !req_err && req_crosses;
`else
  logic req_misaligned;
  assign req_misaligned = (bus.mem_type_i == 2'b01 && bus.addr_i[0]) ||
                          (bus.mem_type_i == 2'b10 && bus.addr_i[1:0] != 2'b00);
  assign req_err        = (bus.mem_type_i == 2'b11) || req_misaligned;
  assign req_split      = 1'b0;
`endif

  assign accept     = (state_q == IDLE) && bus.req_valid_i;
  assign in_acc     = (state_q == ACC0) || (state_q == ACC1);
  assign final_beat = bus.mem_ready_i &&
                      (((state_q == ACC0) && !split_q) || (state_q == ACC1));

  // Lane maps span two words: the low word belongs to ACC0, the high word to ACC1.
  always_comb begin
    case (type_q)
      2'b00:   begin size_mask = 4'h1; wdata_sized = {24'd0, wdata_q[7:0]};  end
      2'b01:   begin size_mask = 4'h3; wdata_sized = {16'd0, wdata_q[15:0]}; end
      default: begin size_mask = 4'hF; wdata_sized = wdata_q;                end
    endcase
  end

  assign strb_span  = {4'd0, size_mask} << addr_q[1:0];
  assign wdata_span = {32'd0, wdata_sized} << {addr_q[1:0], 3'b000};

  assign load_pair = (state_q == ACC1) ? {bus.mem_rdata_i, lo_word_q}
                                       : {32'd0, bus.mem_rdata_i};
  assign load_word = 32'(load_pair >> {addr_q[1:0], 3'b000});

  always_comb begin
    load_ext = load_word;
    case (type_q)
      2'b00:   load_ext = {{24{sign_q & load_word[7]}},  load_word[7:0]};
      2'b01:   load_ext = {{16{sign_q & load_word[15]}}, load_word[15:0]};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      sign_q    <= 1'b0;
      err_q     <= 1'b0;
      split_q   <= 1'b0;
      type_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      lo_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q   <= bus.req_write_i;
        sign_q    <= bus.mem_sign_i;
        type_q    <= bus.mem_type_i;
        addr_q    <= bus.addr_i;
        wdata_q   <= bus.wdata_i;
        err_q     <= req_err;
        split_q   <= req_split;
        lo_word_q <= '0;
        rdata_q   <= '0;
      end
      if ((state_q == ACC0) && bus.mem_ready_i && split_q)
        lo_word_q <= bus.mem_rdata_i;
      if (final_beat && !write_q)
        rdata_q <= load_ext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.mem_req_o    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = req_err ? RESP : ACC0;
      end
      ACC0: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_ready_i) state_d = split_q ? ACC1 : RESP;
      end
      ACC1: begin
        bus.mem_req_o = 1'b1;
        if (bus.mem_ready_i) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid_o = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr_o  = in_acc ? ({addr_q[31:2], 2'b00} + ((state_q == ACC1) ? 32'd4 : 32'd0))
                                  : '0;
  assign bus.mem_we_o    = in_acc && write_q;
  assign bus.mem_wstrb_o = !(in_acc && write_q) ? 4'd0 :
                           (state_q == ACC1) ? strb_span[7:4] : strb_span[3:0];
  assign bus.mem_wdata_o = !(in_acc && write_q) ? 32'd0 :
                           (state_q == ACC1) ? wdata_span[63:32] : wdata_span[31:0];
  assign bus.resp_data_o = (state_q == RESP) ? rdata_q : '0;
  assign bus.resp_err_o  = (state_q == RESP) && err_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk_i  input  1  the single clock; all state updates on the rising edge.
REQ-002 rst_i  input  1  synchronous, active-high reset, sampled on the rising edge of clk_i.
REQ-003 req_valid_i  input  1  CPU load/store request valid.
REQ-004 req_ready_o  output  1  unit idle; the request is accepted when valid and ready are both high.
REQ-005 req_write_i  input  1  1 = store, 0 = load.
REQ-006 mem_type_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 mem_sign_i  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data, right-justified.
REQ-010 resp_valid_o  output  1  one-cycle completion pulse.
REQ-011 resp_data_o  output  32  extended load data; 0 for stores.
REQ-012 resp_err_o  output  1  request rejected; qualified by resp_valid_o.
REQ-013 mem_req_o  output  1  memory access request.
REQ-014 mem_we_o  output  1  memory write enable.
REQ-015 mem_addr_o  output  32  word-aligned address, bits [1:0] = 00.
REQ-016 mem_wdata_o  output  32  store data shifted into byte lanes.
REQ-017 mem_wstrb_o  output  4  byte-lane enables; 0000 for loads.
REQ-018 mem_ready_i  input  1  memory completes the current access this cycle.
REQ-019 mem_rdata_i  input  32  read word; valid when mem_ready_i is high.

Function
REQ-020 The FSM SHALL have states IDLE, ACC0, ACC1 and RESP; req_ready_o SHALL be high only in IDLE.
REQ-021 On acceptance, the unit SHALL register all request fields and move to ACC0 (or RESP on error).
REQ-022 In ACC0/ACC1, mem_req_o SHALL be held high with stable address, data and strobes until mem_ready_i is high.
REQ-023 ACC0 SHALL access word addr_i[31:2]; ACC1 SHALL access the next word, with the 32-bit address wrapping 0xFFFFFFFC -> 0x00000000.
REQ-024 An access needs ACC1 when offset + size exceeds 4, where offset = addr_i[1:0] and size is 1, 2 or 4.
REQ-025 After the final mem_ready_i, the FSM SHALL enter RESP, pulse resp_valid_o for exactly one cycle, then return to IDLE.
REQ-026 Best-case aligned latency: accepted at edge T, mem_req_o high in cycle T+1, resp_valid_o high in cycle T+2.
REQ-027 Load data SHALL be taken as {ACC1 word, ACC0 word} >> (8*offset) and truncated to the access size.
REQ-028 Load data SHALL then be sign- or zero-extended per mem_sign_i; a word load ignores mem_sign_i.
REQ-029 Store strobes SHALL be computed the same way; the ACC0 beat carries the low lanes and the ACC1 beat carries the remainder.
REQ-030 mem_type_i = 11 SHALL give RESP with resp_err_o = 1 and no memory access.
REQ-031 req_valid_i while not in IDLE SHALL be ignored; the CPU holds its request.

Reset
REQ-032 While rst_i is high at a clock edge, the FSM SHALL go to IDLE and clear all registered request fields.
REQ-033 After that edge, mem_req_o, mem_we_o, mem_wstrb_o, resp_valid_o and resp_err_o SHALL be 0, req_ready_o SHALL be 1, and all data/address outputs SHALL be 0.
REQ-034 Reset mid-access SHALL abandon the transaction; no response SHALL be issued for it.

Configuration
REQ-035 With MISALIGN_SPLIT_EN defined, accesses crossing a word boundary SHALL be split across ACC0 and ACC1 as above.
REQ-036 Without MISALIGN_SPLIT_EN, a misaligned halfword or word SHALL go straight to RESP with resp_err_o = 1 and no memory access; ACC1 SHALL NOT be reachable.
REQ-037 A misaligned access is a halfword with addr_i[0] = 1, or a word with addr_i[1:0] != 00.

Verification
REQ-038 Aligned word load, addr 0x100, mem_rdata_i 0xDEADBEEF, mem_ready_i tied 1 -> mem_addr_o 0x100 in T+1; resp_data_o 0xDEADBEEF in T+2.
REQ-039 Signed byte load, addr 0x103, rdata 0x80FF0000 -> resp_data_o 0xFFFFFF80; same access with mem_sign_i = 0 -> 0x00000080.
REQ-040 Halfword store, addr 0x202, wdata 0x0000ABCD -> mem_wstrb_o 1100, mem_wdata_o 0xABCD0000, mem_we_o 1, then a resp_valid_o pulse with resp_data_o 0.
REQ-041 Word load, addr 0x0FFFFFFE, MISALIGN_SPLIT_EN on, rdata 0x3344xxxx then 0xxxxx1122 -> addresses 0x0FFFFFFC then 0x10000000, resp_data_o 0x11223344.
REQ-042 Same request as REQ-041 with MISALIGN_SPLIT_EN off -> no mem_req_o, resp_err_o 1; stalls of 3 cycles on mem_ready_i keep outputs stable.
REQ-043 Assert rst_i during ACC0 with mem_ready_i held 0 -> next cycle mem_req_o 0 and req_ready_o 1, and no resp_valid_o ever for that request.
